tdm_demux: RTL
==============

// Module: tdm_demux
// PURPOSE
//   Receive end of a time-division multiplexed word stream: words arrive one per
//   accepted beat, framed by a start-of-frame marker, and are routed back to
//   CHANNELS parallel outputs. Inverse of a select-driven mux front end.
//   Sits between the serial link and per-channel consumers; presents one
//   complete, registered frame at a time.
// PARAMETERS
//   CHANNELS  4  slots per frame (>=2); slot counter is $clog2(CHANNELS) bits
//   WIDTH     8  bits per word/slot
// PORTS
//   clk       in   1               rising-edge clock, single domain
//   reset     in   1               synchronous, active-high reset
//   in_valid  in   1               in_data/in_sof valid this cycle
//   in_sof    in   1               word is slot 0 of a new frame (qualified by in_valid)
//   in_data   in   WIDTH           incoming word
//   in_par    in   1               even-parity bit for in_data (TDM_PARITY_EN builds only)
//   out_data  out  CHANNELS*WIDTH  slot k at bits [k*WIDTH +: WIDTH], registered
//   out_valid out  1               1-cycle pulse: out_data updated with a new frame
//   frm_err   out  1               1-cycle pulse: frame aborted/rejected
//   busy      out  1               1 while in COLLECT state
// BEHAVIOUR
//   - Reset (sync, high): state=IDLE, slot=0, shadow=0, out_data=0, out_valid=0,
//     frm_err=0, busy=0. Reset mid-frame discards the partial frame; no err pulse.
//   - States: IDLE, COLLECT. Words are written into an internal shadow register.
//   - IDLE: in_valid&in_sof -> shadow[0]=in_data, slot=1, ->COLLECT.
//     in_valid&!in_sof -> word dropped silently, stay IDLE.
//   - COLLECT: in_valid&!in_sof -> shadow[slot]=in_data, slot++.
//     When the written slot is CHANNELS-1: out_data<=shadow with that word
//     merged, out_valid=1 next cycle, slot=0, ->IDLE.
//   - COLLECT: in_valid&in_sof (early SOF) -> frm_err=1 next cycle, partial
//     frame discarded, the SOF word becomes slot 0 of a new frame, slot=1,
//     stay COLLECT. out_data unchanged.
//   - !in_valid: no state change in either state (gaps allowed anywhere).
//   - Latency: last slot accepted at cycle N -> out_valid and new out_data at N+1.
//   - out_data holds its value between frames; only a completed frame writes it.
//   - Back-to-back: SOF of the next frame may arrive the cycle after the last
//     slot; accepted with no bubble (IDLE is left in that same cycle).
//   - Slot counter never wraps past CHANNELS-1; no backpressure (always ready).
//   - busy = (state==COLLECT).
// CONFIGURATION
//   TDM_PARITY_EN defined: in_par checked on every accepted word;
//     mismatch (^{in_data,in_par}!=0) marks the frame bad; at the last slot a bad
//     frame gives frm_err=1 instead of out_valid, out_data unchanged, ->IDLE.
//     Bad flag cleared on every SOF. Parity error on a dropped IDLE word ignored.
//   TDM_PARITY_EN undefined: in_par port present but ignored; no parity logic.
// TESTING (CHANNELS=4, WIDTH=8)
//   - Reset then idle 5 cycles -> out_data=0, out_valid=0, frm_err=0, busy=0.
//   - SOF 0x11, then 0x22,0x33,0x44 consecutive -> one cycle after 0x44:
//     out_valid=1, out_data=0x44332211; out_valid=0 the following cycle.
//   - Same frame with 2-cycle gaps between words -> identical result, busy held
//     high across gaps, out_valid exactly once.
//   - SOF 0xAA,0xBB, then SOF 0x01,0x02,0x03,0x04 -> frm_err pulse after 2nd
//     SOF; out_data=0x04030201 with single out_valid; 0xAA/0xBB never appear.
//   - Non-SOF words 0x55,0x66 in IDLE, then reset asserted mid-frame after
//     SOF 0x10,0x20 -> no out_valid, no frm_err, out_data stays previous value
//     (0 after reset), busy=0.
//   - TDM_PARITY_EN: frame 0x01(par=0 bad),0x02,0x03,0x04 -> frm_err pulse, no
//     out_valid, out_data unchanged; next clean frame -> out_valid normally.

Source files
------------

// File: rtl/tdm_demux.sv
// ============================================================================
// Module   : tdm_demux
// Brief    : Receive-side TDM demultiplexer; collects one framed word per slot
//            and presents each complete frame as a registered parallel word.
//            Optional parity checking is enabled with `define TDM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      in_sof,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_par,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      out_valid,
  output logic                      frm_err,
  output logic                      busy
);

  localparam int SW = $clog2(CHANNELS);
  localparam logic [SW-1:0] c_LAST_SLOT = SW'(CHANNELS - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [SW-1:0]               r_slot, w_slot_nxt;
  logic [CHANNELS*WIDTH-1:0]   r_shadow, w_shadow_nxt;
  logic [CHANNELS*WIDTH-1:0]   r_out_data, w_out_data_nxt;
  logic                        r_out_valid, w_out_valid_nxt;
  logic                        r_frm_err, w_frm_err_nxt;
  logic                        r_bad, w_bad_nxt;
  logic                        w_par_bad;

`ifdef TDM_PARITY_EN
  // Even parity: data plus parity bit must XOR to zero.
  assign w_par_bad = ^{in_data, in_par};
`else
  logic w_unused_par;
  assign w_unused_par = in_par;
  assign w_par_bad    = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_slot_nxt      = r_slot;
    w_shadow_nxt    = r_shadow;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = 1'b0;
    w_frm_err_nxt   = 1'b0;
    w_bad_nxt       = r_bad;
    case (r_state)
      IDLE: begin
        if (in_valid && in_sof) begin
          w_shadow_nxt[WIDTH-1:0] = in_data;
          w_slot_nxt              = SW'(1);
          w_bad_nxt               = w_par_bad;
          w_state_nxt             = COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid && in_sof) begin
          // Early SOF: abandon the partial frame and restart from this word.
          w_frm_err_nxt           = 1'b1;
          w_shadow_nxt[WIDTH-1:0] = in_data;
          w_slot_nxt              = SW'(1);
          w_bad_nxt               = w_par_bad;
        end else if (in_valid) begin
          for (int k = 0; k < CHANNELS; k++) begin
            if (r_slot == SW'(k)) w_shadow_nxt[k*WIDTH +: WIDTH] = in_data;
          end
          if (r_slot == c_LAST_SLOT) begin
            if (r_bad || w_par_bad) begin
              w_frm_err_nxt   = 1'b1;
            end else begin
              w_out_data_nxt  = w_shadow_nxt;
              w_out_valid_nxt = 1'b1;
            end
            w_bad_nxt   = 1'b0;
            w_slot_nxt  = '0;
            w_state_nxt = IDLE;
          end else begin
            w_bad_nxt  = r_bad | w_par_bad;
            w_slot_nxt = r_slot + SW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_slot      <= '0;
      r_shadow    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_frm_err   <= 1'b0;
      r_bad       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_slot      <= w_slot_nxt;
      r_shadow    <= w_shadow_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_frm_err   <= w_frm_err_nxt;
      r_bad       <= w_bad_nxt;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign frm_err   = r_frm_err;
  assign busy      = (r_state == COLLECT);

endmodule

`default_nettype wire
